// File: rtl/bram_burst_controller.sv
// Burst controller for a native single-port BRAM: one run pulse moves num_words
// words in or out, with write data via valid/ready and read data as a beat stream.
module bram_burst_controller #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int RD_LATENCY  = 2,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                    system_clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    mode,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [LEN_WIDTH-1:0]    num_words,
  output logic                    idle,
  output logic                    done,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic [DATA_WIDTH-1:0]   bram_din,
  input  logic [DATA_WIDTH-1:0]   bram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  word_cnt;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic                  last_word;
  logic                  wr_accept;
  logic                  read_issue;

  assign last_word  = (word_cnt == len_q - LEN_WIDTH'(1));
  assign wr_accept  = wr_valid && wr_ready;
  assign read_issue = bram_en && !mode_q;

  always_ff @(posedge system_clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (run) begin
          if (num_words == '0) begin
            state_next = S_DONE;
          end else if (mode) begin
            state_next = S_WRITE;
          end else begin
            state_next = S_READ;
          end
        end
      end
      S_WRITE: begin
        if (wr_accept && last_word) begin
          state_next = S_DONE;
        end
      end
      S_READ: begin
        if (last_word) begin
          state_next = S_DRAIN;
        end
      end
      // The last issue is still on the port in the first DRAIN cycle, so both
      // the port and the return pipe must be empty before finishing.
      S_DRAIN: begin
        if (!bram_en && (rd_pipe == '0)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    idle     = 1'b0;
    done     = 1'b0;
    wr_ready = 1'b0;
    case (state)
      S_IDLE:  idle     = 1'b1;
      S_WRITE: wr_ready = 1'b1;
      S_DONE:  done     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (!reset) begin
      mode_q   <= 1'b0;
      cur_addr <= '0;
      len_q    <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            mode_q   <= mode;
            cur_addr <= start_addr;
            len_q    <= num_words;
            word_cnt <= '0;
          end
        end
        S_WRITE: begin
          if (wr_accept) begin
            cur_addr <= cur_addr + ADDR_WIDTH'(ADDR_STRIDE);
            word_cnt <= word_cnt + LEN_WIDTH'(1);
          end
        end
        S_READ: begin
          cur_addr <= cur_addr + ADDR_WIDTH'(ADDR_STRIDE);
          word_cnt <= word_cnt + LEN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge system_clk) begin
    if (!reset) begin
      bram_en   <= 1'b0;
      bram_we   <= '0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else begin
      bram_en <= 1'b0;
      bram_we <= '0;
      if (wr_accept) begin
        bram_en   <= 1'b1;
        bram_we   <= '1;
        bram_addr <= cur_addr;
        bram_din  <= wr_data;
      end else if (state == S_READ) begin
        bram_en   <= 1'b1;
        bram_addr <= cur_addr;
      end
    end
  end

  // One bit per cycle of BRAM latency; rd_valid is the final stage.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      rd_pipe  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pipe  <= (rd_pipe << 1) | RD_LATENCY'(read_issue);
      rd_valid <= rd_pipe[RD_LATENCY-1];
      if (rd_pipe[RD_LATENCY-1]) begin
        rd_data <= bram_dout;
      end
    end
  end

endmodule

// File: tb/tb_bram_burst_controller.sv
// Directed bench for bram_burst_controller with a two-cycle-latency BRAM model
// and a per-cycle monitor of port writes, read beats and done pulses.
module tb_bram_burst_controller;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int RL = 2;
  localparam int ST = 4;

  logic          system_clk = 1'b0;
  logic          reset;
  logic          run;
  logic          mode;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] num_words;
  logic          idle;
  logic          done;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;

  always #5 system_clk = ~system_clk;

  bram_burst_controller #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .RD_LATENCY (RL),
    .ADDR_STRIDE(ST)
  ) dut (
    .system_clk(system_clk),
    .reset     (reset),
    .run       (run),
    .mode      (mode),
    .start_addr(start_addr),
    .num_words (num_words),
    .idle      (idle),
    .done      (done),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .bram_addr (bram_addr),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_din  (bram_din),
    .bram_dout (bram_dout)
  );

  // BRAM model: enable sampled at edge 1, data visible after edge 2.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] rd_stage;

  always @(posedge system_clk) begin
    if (bram_en) begin
      if (bram_we == 4'hF) mem[bram_addr[AW-1:2]] <= bram_din;
      rd_stage <= mem[bram_addr[AW-1:2]];
    end
    bram_dout <= rd_stage;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] we;
    int          cyc;
  } bus_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } beat_t;

  bus_t  en_q[$];
  beat_t rd_q[$];
  int    done_q[$];
  bus_t  mon_e;
  beat_t mon_b;
  int    cyc = 0;

  always @(posedge system_clk) cyc <= cyc + 1;

  always @(negedge system_clk) begin
    if (bram_en) begin
      mon_e.addr = 32'(bram_addr);
      mon_e.data = bram_din;
      mon_e.we   = 32'(bram_we);
      mon_e.cyc  = cyc;
      en_q.push_back(mon_e);
    end
    if (rd_valid) begin
      mon_b.data = rd_data;
      mon_b.cyc  = cyc;
      rd_q.push_back(mon_b);
    end
    if (done) done_q.push_back(cyc);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses run for one edge and returns at the first cycle of the burst.
  task automatic applyStimulus(input logic m, input logic [AW-1:0] a, input logic [LW-1:0] n);
    @(negedge system_clk);
    run        = 1'b1;
    mode       = m;
    start_addr = a;
    num_words  = n;
    @(negedge system_clk);
    run = 1'b0;
  endtask

  task automatic drive_writes(input bit gaps, input int cycles);
    int word = 0;
    for (int t = 0; t < cycles; t++) begin
      wr_valid = gaps ? (t % 2 == 0) : 1'b1;
      wr_data  = 32'(word);
      if (wr_valid && wr_ready) word++;
      @(negedge system_clk);
    end
    wr_valid = 1'b0;
  endtask

  int eb, rb, db, beats;

  initial begin
    reset      = 1'b0;
    run        = 1'b1;
    mode       = 1'b1;
    start_addr = '0;
    num_words  = 8'd5;
    wr_valid   = 1'b0;
    wr_data    = '0;

    $display("[TB] reset held with run asserted");
    repeat (3) begin
      @(negedge system_clk);
      checkOutput("rst_idle", 32'(idle), 32'd1);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
      checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("rst_bram_en", 32'(bram_en), 32'd0);
    end
    reset = 1'b1;
    run   = 1'b0;
    @(negedge system_clk);
    checkOutput("post_rst_idle", 32'(idle), 32'd1);
    repeat (2) @(negedge system_clk);
    #1;

    $display("[TB] write burst, wr_valid held high");
    eb = en_q.size();
    db = done_q.size();
    applyStimulus(1'b1, 12'h000, 8'd10);
    drive_writes(1'b0, 20);
    #1;
    checkOutput("wr_count", 32'(en_q.size() - eb), 32'd10);
    if (en_q.size() - eb == 10) begin
      for (int i = 0; i < 10; i++) begin
        checkOutput("wr_addr", en_q[eb+i].addr, 32'(i * 4));
        checkOutput("wr_data", en_q[eb+i].data, 32'(i));
        checkOutput("wr_we", en_q[eb+i].we, 32'hF);
        checkOutput("wr_consecutive", 32'(en_q[eb+i].cyc - en_q[eb].cyc), 32'(i));
      end
      checkOutput("wr_done_count", 32'(done_q.size() - db), 32'd1);
      if (done_q.size() - db == 1)
        checkOutput("wr_done_with_last", 32'(done_q[db]), 32'(en_q[eb+9].cyc));
    end
    checkOutput("wr_ready_dropped", 32'(wr_ready), 32'd0);

    $display("[TB] write burst, wr_valid toggling");
    eb = en_q.size();
    db = done_q.size();
    applyStimulus(1'b1, 12'h000, 8'd10);
    drive_writes(1'b1, 30);
    #1;
    checkOutput("gap_count", 32'(en_q.size() - eb), 32'd10);
    if (en_q.size() - eb == 10) begin
      for (int i = 0; i < 10; i++) begin
        checkOutput("gap_addr", en_q[eb+i].addr, 32'(i * 4));
        checkOutput("gap_data", en_q[eb+i].data, 32'(i));
        if (i > 0)
          checkOutput("gap_spacing", 32'(en_q[eb+i].cyc - en_q[eb+i-1].cyc), 32'd2);
      end
    end
    checkOutput("gap_done_count", 32'(done_q.size() - db), 32'd1);

    $display("[TB] read burst from address 4");
    eb = en_q.size();
    rb = rd_q.size();
    db = done_q.size();
    applyStimulus(1'b0, 12'h004, 8'd9);
    repeat (25) @(negedge system_clk);
    #1;
    checkOutput("rd_issue_count", 32'(en_q.size() - eb), 32'd9);
    checkOutput("rd_beat_count", 32'(rd_q.size() - rb), 32'd9);
    if (en_q.size() - eb == 9 && rd_q.size() - rb == 9) begin
      for (int i = 0; i < 9; i++) begin
        checkOutput("rd_addr", en_q[eb+i].addr, 32'(4 + i * 4));
        checkOutput("rd_we", en_q[eb+i].we, 32'h0);
        checkOutput("rd_data", rd_q[rb+i].data, 32'(i + 1));
        checkOutput("rd_consecutive", 32'(rd_q[rb+i].cyc - rd_q[rb].cyc), 32'(i));
      end
      checkOutput("rd_first_latency", 32'(rd_q[rb].cyc - en_q[eb].cyc), 32'd3);
      checkOutput("rd_done_count", 32'(done_q.size() - db), 32'd1);
      if (done_q.size() - db == 1)
        checkOutput("rd_done_after_last", 32'(done_q[db] - rd_q[rb+8].cyc), 32'd1);
    end

    $display("[TB] address wrap");
    eb = en_q.size();
    applyStimulus(1'b0, 12'hFF8, 8'd4);
    repeat (15) @(negedge system_clk);
    #1;
    checkOutput("wrap_count", 32'(en_q.size() - eb), 32'd4);
    if (en_q.size() - eb == 4) begin
      checkOutput("wrap_addr0", en_q[eb].addr, 32'hFF8);
      checkOutput("wrap_addr1", en_q[eb+1].addr, 32'hFFC);
      checkOutput("wrap_addr2", en_q[eb+2].addr, 32'h000);
      checkOutput("wrap_addr3", en_q[eb+3].addr, 32'h004);
    end

    $display("[TB] zero-length burst");
    eb = en_q.size();
    db = done_q.size();
    applyStimulus(1'b1, 12'h040, 8'd0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_not_idle", 32'(idle), 32'd0);
    @(negedge system_clk);
    checkOutput("zero_done_drop", 32'(done), 32'd0);
    checkOutput("zero_idle_back", 32'(idle), 32'd1);
    repeat (3) @(negedge system_clk);
    #1;
    checkOutput("zero_no_access", 32'(en_q.size() - eb), 32'd0);
    checkOutput("zero_done_count", 32'(done_q.size() - db), 32'd1);

    $display("[TB] run pulsed during a read burst");
    eb = en_q.size();
    rb = rd_q.size();
    db = done_q.size();
    applyStimulus(1'b0, 12'h000, 8'd5);
    repeat (2) @(negedge system_clk);
    run        = 1'b1;
    mode       = 1'b1;
    start_addr = 12'h100;
    num_words  = 8'd3;
    @(negedge system_clk);
    run = 1'b0;
    repeat (15) @(negedge system_clk);
    #1;
    checkOutput("midrun_issue_count", 32'(en_q.size() - eb), 32'd5);
    if (en_q.size() - eb == 5) begin
      for (int i = 0; i < 5; i++) begin
        checkOutput("midrun_addr", en_q[eb+i].addr, 32'(i * 4));
        checkOutput("midrun_we", en_q[eb+i].we, 32'h0);
      end
    end
    checkOutput("midrun_beat_count", 32'(rd_q.size() - rb), 32'd5);
    if (rd_q.size() - rb == 5) begin
      for (int i = 0; i < 5; i++)
        checkOutput("midrun_data", rd_q[rb+i].data, 32'(i));
    end
    checkOutput("midrun_done_count", 32'(done_q.size() - db), 32'd1);

    $display("[TB] reset during a read burst");
    rb = rd_q.size();
    db = done_q.size();
    applyStimulus(1'b0, 12'h000, 8'd9);
    beats = 0;
    for (int t = 0; t < 30 && beats < 3; t++) begin
      @(negedge system_clk);
      #1;
      if (rd_valid) beats++;
    end
    checkOutput("abort_wait_beats", 32'(beats), 32'd3);
    reset = 1'b0;
    @(negedge system_clk);
    #1;
    checkOutput("abort_idle", 32'(idle), 32'd1);
    checkOutput("abort_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("abort_bram_en", 32'(bram_en), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    reset = 1'b1;
    repeat (12) @(negedge system_clk);
    #1;
    checkOutput("abort_beats_total", 32'(rd_q.size() - rb), 32'd3);
    checkOutput("abort_no_done", 32'(done_q.size() - db), 32'd0);
    checkOutput("abort_idle_after", 32'(idle), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_burst_controller.md
Name: bram_burst_controller

Overview:
Parametrised next-generation single-port BRAM controller. One run pulse starts a multi-word burst, either a write or a read, from a start address. Write data enters through a valid/ready handshake. Read data leaves as a stream of rd_valid beats in address order. The block drives a native BRAM port with byte write-enables and configurable read latency, and replaces the single-word run/done controller inside the block design.

Parameters:
ADDR_WIDTH, 12, byte-address width of the BRAM port
DATA_WIDTH, 32, word width; must be a multiple of 8
LEN_WIDTH, 8, width of num_words (max burst = 2^LEN_WIDTH-1 words)
RD_LATENCY, 2, cycles from bram_en (read) sampled to bram_dout valid; legal 1..3
ADDR_STRIDE, 4, byte-address increment per word

Ports:
system_clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
run  in  1  start pulse, accepted only while idle=1
mode  in  1  1 = write burst, 0 = read burst; latched with run
start_addr  in  ADDR_WIDTH  first byte address; latched with run
num_words  in  LEN_WIDTH  burst length; latched with run
idle  out  1  high only in IDLE
done  out  1  one-cycle pulse at burst end
wr_data  in  DATA_WIDTH  write word
wr_valid  in  1  wr_data valid
wr_ready  out  1  controller accepts wr_data
rd_data  out  DATA_WIDTH  read word, registered
rd_valid  out  1  rd_data valid, one cycle per word, no backpressure
bram_addr  out  ADDR_WIDTH  BRAM address, registered
bram_en  out  1  BRAM enable, registered
bram_we  out  DATA_WIDTH/8  byte write enables, registered
bram_din  out  DATA_WIDTH  BRAM write data, registered
bram_dout  in  DATA_WIDTH  BRAM read data

Behaviour:
- States: IDLE, WRITE, READ, DRAIN, DONE.
- Reset (reset=0 at an edge) forces IDLE from any state:
  - idle=1; done, wr_ready, rd_valid, bram_en, bram_we = 0.
  - rd_data, bram_addr, bram_din = 0.
  - An in-flight burst is aborted: no done pulse, pending read beats discarded.
- IDLE:
  - run=1 at an edge latches mode, start_addr and num_words, clears the word counter, and moves to WRITE or READ.
  - If num_words=0, moves straight to DONE with no BRAM access.
  - run in any other state is ignored.
- WRITE:
  - wr_ready=1 throughout the state (combinational from state).
  - Each edge with wr_valid&&wr_ready writes one word. In the next cycle bram_en=1, bram_we=all ones, bram_addr=current address, bram_din=wr_data.
  - Cycles with wr_valid=0 produce bram_en=0 and bram_we=0.
  - The accept of word num_words moves the state to DONE, so wr_ready is 0 in the following cycle.
- READ:
  - Issues one read per cycle for num_words consecutive cycles: bram_en=1, bram_we=0, address incrementing.
  - After the last issue, moves to DRAIN.
- DRAIN: waits until all outstanding reads have returned, then moves to DONE.
- Read return path: a RD_LATENCY+1 deep valid shift register tracks each issue.
  - rd_data captures bram_dout; rd_valid pulses exactly RD_LATENCY+1 cycles after the corresponding bram_en cycle.
  - Beats are consecutive and in address order.
- DONE:
  - done=1 for exactly one cycle, idle=0; next state IDLE.
  - For reads, done is asserted the cycle after the last rd_valid.
  - For writes, done is asserted in the same cycle as the last bram write.
- Address arithmetic:
  - addr(k) = start_addr + k*ADDR_STRIDE, modulo 2^ADDR_WIDTH; wrap-around is silent.
  - The word counter is LEN_WIDTH bits wide and never overflows.
- idle is combinational from state. The first cycle idle=1 after done, run is accepted, giving back-to-back bursts with one IDLE cycle between them.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with run=1 -> idle=1; done, wr_ready, rd_valid, bram_en = 0; no burst starts.
2. Write burst: mode=1, start_addr=0, num_words=10, wr_data=0..9 with wr_valid held high -> 10 consecutive writes to addr 0,4,...,36 with data 0..9 and bram_we=4'hF; wr_ready drops after 10 accepts; one done pulse.
3. Write with gaps: same burst, wr_valid toggling every cycle -> exactly 10 bram_en cycles, none in gap cycles, data and addresses as in scenario 2.
4. Read: mode=0, start_addr=4, num_words=9, RD_LATENCY=2, BRAM preloaded by scenario 2 -> rd_valid high for 9 consecutive cycles with rd_data 1..9; first rd_valid 3 cycles after the first bram_en; done the cycle after the last rd_valid.
5. Wrap: start_addr=12'hFF8, num_words=4 -> bram_addr sequence FF8, FFC, 000, 004.
6. Edge cases:
   - num_words=0 -> done the next cycle, no bram_en.
   - run pulsed mid-burst -> ignored.
   - reset=0 mid-read after 3 beats -> rd_valid stops, idle=1, no done.
